// File: rtl/bk_adder_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : bk_adder_pipe_if
// Brief    : Operand/result valid-ready bundle for the pipelined BK adder.
// Revision : 1.0 - initial release
// ============================================================================
interface bk_adder_pipe_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/bk_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bk_adder_pipe
// Brief    : Pipelined Brent-Kung prefix adder/subtractor, valid/ready flow.
// Revision : 1.0 - initial release
// ============================================================================
module bk_adder_pipe #(
    parameter int WIDTH = 12,
    parameter int PIPE  = 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    bk_adder_pipe_if.slave bus
);

    localparam int c_LOG = $clog2(WIDTH);
    localparam int c_NP  = 1 << c_LOG;

    generate
        if (PIPE < 1 || PIPE > 3) begin : g_bad_pipe
            $fatal(1, "bk_adder_pipe: PIPE must be 1, 2 or 3");
        end
        if (WIDTH < 2) begin : g_bad_width
            $fatal(1, "bk_adder_pipe: WIDTH must be at least 2");
        end
    endgenerate

    // Up-sweep: span-doubling group (g,p) lands on positions 2^k-1.
    function automatic logic [2*c_NP-1:0] f_up_sweep(
        input logic [c_NP-1:0] g_in,
        input logic [c_NP-1:0] p_in
    );
        logic [c_NP-1:0] g;
        logic [c_NP-1:0] p;
        g = g_in;
        p = p_in;
        for (int k = 1; k <= c_LOG; k++) begin
            for (int i = 0; i < c_NP; i++) begin
                if (((i + 1) % (1 << k)) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << (k - 1))]);
                    p[i] = p[i] & p[i - (1 << (k - 1))];
                end
            end
        end
        return {g, p};
    endfunction

    // Down-sweep: fill in the prefixes the up-sweep skipped, widest span first.
    function automatic logic [c_NP-1:0] f_down_sweep(
        input logic [c_NP-1:0] g_in,
        input logic [c_NP-1:0] p_in
    );
        logic [c_NP-1:0] g;
        g = g_in;
        for (int k = c_LOG - 1; k >= 1; k--) begin
            for (int i = 0; i < c_NP; i++) begin
                if ((((i + 1) % (1 << k)) == (1 << (k - 1))) && (i >= (1 << k))) begin
                    g[i] = g[i] | (p_in[i] & g[i - (1 << (k - 1))]);
                end
            end
        end
        return g;
    endfunction

    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    logic [c_NP-1:0]  w_gen_g;
    logic [c_NP-1:0]  w_gen_p;

    logic             w_up_valid;
    logic [c_NP-1:0]  w_up_g;
    logic [c_NP-1:0]  w_up_p;
    logic [WIDTH-1:0] w_up_pb;
    logic             w_up_c0;
    logic [c_NP-1:0]  w_swept_g;
    logic [c_NP-1:0]  w_swept_p;

    logic             w_dn_valid;
    logic [c_NP-1:0]  w_dn_g;
    logic [c_NP-1:0]  w_dn_p;
    logic [WIDTH-1:0] w_dn_pb;
    logic             w_dn_c0;
    logic [c_NP-1:0]  w_final_g;
    logic [WIDTH-1:0] w_carry;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;
    logic             r_out_ovf;
    logic             w_unused;

    assign w_en         = ~r_out_valid | bus.out_ready;
    assign bus.in_ready = w_en;

    // Carry-in is folded into bit 0 as a generate from position -1.
    always_comb begin
        w_b_eff            = bus.in_sub ? ~bus.in_b : bus.in_b;
        w_c0               = bus.in_sub | bus.in_cin;
        w_gen_g            = '0;
        w_gen_p            = '0;
        w_gen_p[WIDTH-1:0] = bus.in_a ^ w_b_eff;
        w_gen_g[WIDTH-1:0] = bus.in_a & w_b_eff;
        w_gen_g[0]         = w_gen_g[0] | (w_gen_p[0] & w_c0);
    end

    generate
        if (PIPE == 3) begin : g_front_reg
            logic            r_s0_valid;
            logic [c_NP-1:0] r_s0_g;
            logic [c_NP-1:0] r_s0_p;
            logic            r_s0_c0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s0_valid <= 1'b0;
                    r_s0_g     <= '0;
                    r_s0_p     <= '0;
                    r_s0_c0    <= 1'b0;
                end else if (w_en) begin
                    r_s0_valid <= bus.in_valid;
                    r_s0_g     <= w_gen_g;
                    r_s0_p     <= w_gen_p;
                    r_s0_c0    <= w_c0;
                end
            end

            assign w_up_valid = r_s0_valid;
            assign w_up_g     = r_s0_g;
            assign w_up_p     = r_s0_p;
            assign w_up_pb    = r_s0_p[WIDTH-1:0];
            assign w_up_c0    = r_s0_c0;
        end else begin : g_front_comb
            assign w_up_valid = bus.in_valid;
            assign w_up_g     = w_gen_g;
            assign w_up_p     = w_gen_p;
            assign w_up_pb    = w_gen_p[WIDTH-1:0];
            assign w_up_c0    = w_c0;
        end
    endgenerate

    assign {w_swept_g, w_swept_p} = f_up_sweep(w_up_g, w_up_p);

    generate
        if (PIPE >= 2) begin : g_mid_reg
            logic             r_s1_valid;
            logic [c_NP-1:0]  r_s1_g;
            logic [c_NP-1:0]  r_s1_p;
            logic [WIDTH-1:0] r_s1_pb;
            logic             r_s1_c0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1_valid <= 1'b0;
                    r_s1_g     <= '0;
                    r_s1_p     <= '0;
                    r_s1_pb    <= '0;
                    r_s1_c0    <= 1'b0;
                end else if (w_en) begin
                    r_s1_valid <= w_up_valid;
                    r_s1_g     <= w_swept_g;
                    r_s1_p     <= w_swept_p;
                    r_s1_pb    <= w_up_pb;
                    r_s1_c0    <= w_up_c0;
                end
            end

            assign w_dn_valid = r_s1_valid;
            assign w_dn_g     = r_s1_g;
            assign w_dn_p     = r_s1_p;
            assign w_dn_pb    = r_s1_pb;
            assign w_dn_c0    = r_s1_c0;
        end else begin : g_mid_comb
            assign w_dn_valid = w_up_valid;
            assign w_dn_g     = w_swept_g;
            assign w_dn_p     = w_swept_p;
            assign w_dn_pb    = w_up_pb;
            assign w_dn_c0    = w_up_c0;
        end
    endgenerate

    assign w_final_g = f_down_sweep(w_dn_g, w_dn_p);
    // Carry into bit i is the prefix generate of bits [i-1:0]; bit 0 takes c0.
    assign w_carry   = {w_final_g[WIDTH-2:0], w_dn_c0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= w_dn_valid;
            r_out_sum   <= w_dn_pb ^ w_carry;
            r_out_cout  <= w_final_g[WIDTH-1];
            r_out_ovf   <= w_final_g[WIDTH-1] ^ w_final_g[WIDTH-2];
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_cout  = r_out_cout;
    assign bus.out_ovf   = r_out_ovf;

    // Padding lanes and tree propagate terms that never reach an output.
    assign w_unused = ^{w_final_g, w_dn_g, w_dn_p, w_up_g, w_up_p, w_swept_g, w_swept_p};

endmodule
`default_nettype wire

// File: tb/tb_bk_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bk_adder_pipe
// Brief    : Directed and randomized bench over several WIDTH/PIPE instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bk_adder_pipe;

    localparam int N           = 9;
    localparam int W_TAB [N]   = '{12, 12, 12, 2, 7, 16, 33, 33, 2};
    localparam int P_TAB [N]   = '{1, 2, 3, 1, 2, 3, 1, 2, 3};
    localparam int RAND_CYCLES = 16000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        d_valid [N];
    logic [63:0] d_a     [N];
    logic [63:0] d_b     [N];
    logic        d_cin   [N];
    logic        d_sub   [N];
    logic        d_ordy  [N];
    logic        o_irdy  [N];
    logic        o_ovalid[N];
    logic [63:0] o_sum   [N];
    logic        o_cout  [N];
    logic        o_ovf   [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            bk_adder_pipe_if #(.WIDTH(W_TAB[gi])) bus ();
            assign bus.in_valid  = d_valid[gi];
            assign bus.in_a      = d_a[gi][W_TAB[gi]-1:0];
            assign bus.in_b      = d_b[gi][W_TAB[gi]-1:0];
            assign bus.in_cin    = d_cin[gi];
            assign bus.in_sub    = d_sub[gi];
            assign bus.out_ready = d_ordy[gi];
            assign o_irdy[gi]    = bus.in_ready;
            assign o_ovalid[gi]  = bus.out_valid;
            assign o_sum[gi]     = 64'(bus.out_sum);
            assign o_cout[gi]    = bus.out_cout;
            assign o_ovf[gi]     = bus.out_ovf;

            bk_adder_pipe #(.WIDTH(W_TAB[gi]), .PIPE(P_TAB[gi])) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );
        end
    endgenerate

    int tests = 0;
    int fails = 0;

    logic [65:0] sb_mem   [N][64];
    int          sb_wr    [N];
    int          sb_rd    [N];
    logic        hold_pend[N];
    logic [67:0] hold_snap[N];

    // Reference: plain modular arithmetic, result packed as {ovf, cout, sum}.
    function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub, input int w);
        logic [64:0] mask, aa, bb, full;
        logic [63:0] s;
        logic        c0, co, ov;
        mask = (65'd1 << w) - 65'd1;
        aa   = {1'b0, a} & mask;
        bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        c0   = sub ? 1'b1 : cin;
        full = aa + bb + 65'(c0);
        s    = full[63:0] & mask[63:0];
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, co, s};
    endfunction

    task automatic check(input string tag, input int inst, input logic [67:0] obs, input logic [67:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, inst, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub);
        d_valid[i] = v;
        d_a[i]     = a;
        d_b[i]     = b;
        d_cin[i]   = cin;
        d_sub[i]   = sub;
    endtask

    task automatic chk_out(input string tag, input int i, input logic ov, input logic co, input logic [63:0] s);
        check(tag, i, {o_ovalid[i], o_ovf[i], o_cout[i], o_sum[i]}, {1'b1, ov, co, s});
    endtask

    task automatic flush_all();
        for (int i = 0; i < N; i++) begin
            sb_rd[i]     = sb_wr[i];
            hold_pend[i] = 1'b0;
        end
    endtask

    // One clock: evaluate handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                hold_pend[i] = 1'b0;
            end else begin
                check("in_ready", i, 68'(o_irdy[i]), 68'(!o_ovalid[i] || d_ordy[i]));
                if (hold_pend[i])
                    check("stall_hold", i, {o_ovalid[i], o_ovf[i], o_cout[i], o_sum[i]}, hold_snap[i]);
                hold_pend[i] = o_ovalid[i] && !d_ordy[i];
                hold_snap[i] = {o_ovalid[i], o_ovf[i], o_cout[i], o_sum[i]};
                if (o_ovalid[i] && d_ordy[i]) begin
                    check("result_expected", i, 68'(sb_wr[i] != sb_rd[i]), 68'(1));
                    if (sb_wr[i] != sb_rd[i]) begin
                        check("result", i, {2'b00, o_ovf[i], o_cout[i], o_sum[i]},
                              {2'b00, sb_mem[i][sb_rd[i] % 64]});
                        sb_rd[i]++;
                    end
                end
                if (d_valid[i] && o_irdy[i]) begin
                    sb_mem[i][sb_wr[i] % 64] = model(d_a[i], d_b[i], d_cin[i], d_sub[i], W_TAB[i]);
                    sb_wr[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            drive(i, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 1'b0);
            d_ordy[i]    = 1'b1;
            hold_pend[i] = 1'b0;
            hold_snap[i] = '0;
            sb_wr[i]     = 0;
            sb_rd[i]     = 0;
        end
        tick();
        tick();
        for (int i = 0; i < N; i++)
            check("rst_in_ready", i, 68'(o_irdy[i]), 68'(1));
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            drive(i, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++)
            check("reset_state", i, {o_irdy[i], o_ovalid[i], o_ovf[i], o_cout[i], o_sum[i]},
                  {1'b1, 67'd0});

        // PIPE=1 add/sub boundaries, one cycle latency
        drive(0, 1'b1, 64'hFFF, 64'h001, 1'b0, 1'b0); tick();
        chk_out("p1_add_wrap", 0, 1'b0, 1'b1, 64'h000);
        drive(0, 1'b1, 64'h7FF, 64'h001, 1'b0, 1'b0); tick();
        chk_out("p1_add_ovf", 0, 1'b1, 1'b0, 64'h800);
        drive(0, 1'b1, 64'h000, 64'h001, 1'b1, 1'b1); tick();
        chk_out("p1_sub_borrow", 0, 1'b0, 1'b0, 64'hFFF);
        drive(0, 1'b1, 64'h800, 64'h001, 1'b1, 1'b1); tick();
        chk_out("p1_sub_ovf", 0, 1'b1, 1'b1, 64'h7FF);
        drive(0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0); tick();
        check("p1_idle", 0, 68'(o_ovalid[0]), 68'(0));

        // PIPE=3 back-to-back, first result after edge N+2
        drive(2, 1'b1, 64'h123, 64'h456, 1'b0, 1'b0); tick();
        drive(2, 1'b1, 64'hABC, 64'h111, 1'b0, 1'b0); tick();
        check("p3_latency", 2, 68'(o_ovalid[2]), 68'(0));
        drive(2, 1'b1, 64'hFFF, 64'hFFF, 1'b1, 1'b0); tick();
        chk_out("p3_b2b_0", 2, 1'b0, 1'b0, 64'h579);
        drive(2, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0); tick();
        chk_out("p3_b2b_1", 2, 1'b0, 1'b0, 64'hBCD);
        tick();
        chk_out("p3_b2b_2", 2, 1'b0, 1'b1, 64'hFFF);
        tick();

        // PIPE=3 backpressure with three beats in flight and a fourth waiting
        d_ordy[2] = 1'b0;
        drive(2, 1'b1, 64'h001, 64'h002, 1'b0, 1'b0); tick();
        drive(2, 1'b1, 64'h0F0, 64'h00F, 1'b0, 1'b0); tick();
        drive(2, 1'b1, 64'h800, 64'h800, 1'b0, 1'b0); tick();
        drive(2, 1'b1, 64'h555, 64'h0AA, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("bp_in_ready", 2, 68'(o_irdy[2]), 68'(0));
            chk_out("bp_frozen", 2, 1'b0, 1'b0, 64'h003);
            tick();
        end
        d_ordy[2] = 1'b1; tick();
        drive(2, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        chk_out("bp_rel_1", 2, 1'b0, 1'b0, 64'h0FF); tick();
        chk_out("bp_rel_2", 2, 1'b1, 1'b1, 64'h000); tick();
        chk_out("bp_rel_3", 2, 1'b0, 1'b0, 64'h5FF); tick();
        check("bp_drained", 2, 68'(o_ovalid[2]), 68'(0));

        // PIPE=2 reset with two beats in flight
        d_ordy[1] = 1'b0;
        drive(1, 1'b1, 64'h100, 64'h200, 1'b0, 1'b0); tick();
        drive(1, 1'b1, 64'h321, 64'h123, 1'b0, 1'b0); tick();
        chk_out("p2_before_rst", 1, 1'b0, 1'b0, 64'h300);
        drive(1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        rst = 1'b1; tick();
        check("p2_after_rst", 1, {o_irdy[1], o_ovalid[1], o_ovf[1], o_cout[1], o_sum[1]}, {1'b1, 67'd0});
        rst = 1'b0;
        flush_all();
        d_ordy[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("p2_no_stale", 1, 68'(o_ovalid[1]), 68'(0));
        end

        // Random traffic on every instance against the scoreboard
        for (int c = 0; c < RAND_CYCLES; c++) begin
            for (int i = 0; i < N; i++) begin
                d_valid[i] = ($urandom_range(3) != 0);
                d_a[i]     = ($urandom_range(7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
                d_b[i]     = ($urandom_range(7) == 0) ? 64'h0 : {$urandom, $urandom};
                d_cin[i]   = 1'($urandom_range(1));
                d_sub[i]   = 1'($urandom_range(1));
                d_ordy[i]  = ($urandom_range(3) != 0);
            end
            tick();
        end
        for (int i = 0; i < N; i++) begin
            d_valid[i] = 1'b0;
            d_ordy[i]  = 1'b1;
        end
        repeat (8) tick();
        for (int i = 0; i < N; i++)
            check("drained", i, 68'(sb_wr[i] - sb_rd[i]), 68'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bk_adder_pipe.md
# bk_adder_pipe

Parametrised, pipelined Brent-Kung prefix adder/subtractor for the arithmetic playground benchmarks. It is the sequential successor to the fixed 12-bit combinational Brent-Kung adder. It adds configurable width, add/subtract mode, carry-in and signed-overflow detection. It also adds a configurable register depth behind a valid/ready handshake, so synthesis-flow experiments can trade prefix-tree depth against cycle time.

## Interface
- WIDTH, 12: operand width in bits; any integer ≥ 2 (prefix tree padded internally to next power of two, padding bits g=0/p=0).
- PIPE, 1: register depth, legal values 1, 2, 3; other values are an elaboration error.
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in (ignored when in_sub=1).
- in_sub  input  1  0: A+B+cin; 1: A−B (A + ~B + 1).
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  result bits [WIDTH-1:0].
- out_cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
- out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Datapath per beat: b' = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin; bitwise g_i = a_i & b'_i, p_i = a_i ^ b'_i; Brent-Kung up-sweep (log2 levels, span-doubling group g/p at positions 2^k−1), down-sweep (fill-in of remaining prefixes); c0 folded in as position −1 generate; sum_i = p_i ^ c_i.
- Pipeline cut points, each a full register of valid bit + all live data:
  - PIPE=1: output register only.
  - PIPE=2: after up-sweep; down-sweep + sum + output register in stage 2.
  - PIPE=3: after g/p generation; after up-sweep; output register.
- Flow control: single global advance enable en = ~out_valid | out_ready. When en=1 every stage shifts forward one position and stage 0 captures in_valid and operands. When en=0 all stages hold.
- in_ready = en. This is a combinational path from out_ready and out_valid. A beat transfers when in_valid & in_ready. A result is consumed when out_valid & out_ready.
- Internal bubbles (valid=0 stages) advance like data; a bubble never stalls the pipe unless it is in the last stage with out_valid=1, which is impossible by definition.
- Results leave in acceptance order; no reordering and no drops. Beats accepted while the pipe is stalled are impossible since in_ready=0.
- Width rules: all arithmetic is modulo 2^WIDTH; out_cout/out_ovf computed from the true carries, never from padding bits.

## Timing
- Latency: a beat accepted at edge N appears on out_valid/out_sum after edge N+PIPE−1 (visible in cycle following edge N+PIPE−1), absent stalls; PIPE=1 result visible the cycle after acceptance.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 freezes all outputs and internal stages bit-for-bit until out_ready rises.
- Reset (rst=1 at an edge): all stage valid bits, out_valid, out_sum, out_cout, out_ovf clear to 0 on that edge. Beats in flight are discarded. in_ready reads 1 during and after reset (out_valid=0). Operands presented with in_valid during the reset cycle are not captured.
- Simultaneous consume + accept in a full pipe: allowed in same cycle, no bubble inserted.

## Test plan
- WIDTH=12, PIPE=1, add: A=0xFFF, B=0x001, cin=0 -> sum=0x000, cout=1, ovf=0 one cycle later; A=0x7FF, B=0x001 -> sum=0x800, cout=0, ovf=1.
- WIDTH=12, subtract: A=0x000, B=0x001 -> sum=0xFFF, cout=0, ovf=0; A=0x800, B=0x001 -> sum=0x7FF, cout=1, ovf=1; cin=1 ignored in both cases.
- WIDTH=12, PIPE=3, back-to-back beats 0x123+0x456, 0xABC+0x111, 0xFFF+0xFFF (cin=1) -> 0x579/0, 0xBCD/0, 0xFFF/1 on consecutive cycles starting 3 cycles after first accept (edge N+2).
- Backpressure, PIPE=3: hold out_ready=0 for 5 cycles with 3 beats in flight -> in_ready=0, outputs frozen; release -> all 3 results in order, no loss or duplicate.
- Reset mid-flight, PIPE=2: assert rst with 2 beats in flight -> next cycle out_valid=0, out_sum=0, cout=0, ovf=0; no stale result ever emerges.
- Random: WIDTH ∈ {2, 7, 16, 33}, PIPE ∈ {1,2,3}, 10k beats with random in_valid/out_ready -> every result matches a behavioural {cout,sum} = a + b' + c0 model and ovf equation, in order.
